// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM responder with programmable wait states and a MemReady/MemFault handshake.
// Define MEM_RESPONDER_RANGE_CHECK_EN to fault requests with Addr >= DEPTH instead of wrapping them modulo DEPTH.
module mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       WriteData,
  output logic [15:0]       ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              MemFault
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, in_idx, acc_idx;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, acc_data;
  logic wr_q, wr_d, fault_q, fault_d, ready_q, ready_d;
  logic idle, accept, in_fault, go, acc_wr, acc_fault, do_write;
  logic [15:0] mem [DEPTH];
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign in_idx   = Addr[IW-1:0];
  assign in_fault = (MemRead & MemWrite) | (32'(Addr) >= 32'(DEPTH));
`else
  assign in_idx   = IW'(32'(Addr) % DEPTH);
  assign in_fault = MemRead & MemWrite;
`endif
  assign idle   = state_q == S_IDLE;
  assign accept = idle && (MemRead || MemWrite);
  // With zero wait states the access happens on the acceptance edge itself, straight from the live inputs
  assign go        = idle ? accept && WAIT_STATES == 0 : state_q == S_WAIT && cnt_q == 4'd0;
  assign acc_idx   = idle ? in_idx : idx_q;
  assign acc_data  = idle ? WriteData : wdata_q;
  assign acc_wr    = idle ? MemWrite : wr_q;
  assign acc_fault = idle ? in_fault : fault_q;
  assign do_write  = Reset && go && acc_wr && !acc_fault;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    rdata_d = go && !acc_wr && !acc_fault ? mem[acc_idx] : rdata_q;
    if (accept) begin
      idx_d   = in_idx;
      wdata_d = WriteData;
      wr_d    = MemWrite;
      fault_d = in_fault;
      state_d = WAIT_STATES == 0 ? S_DONE : S_WAIT;
      cnt_d   = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
    end else if (state_q == S_WAIT) begin
      state_d = go ? S_DONE : S_WAIT;
      cnt_d   = go ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    ready_d = state_d == S_DONE;
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 16'd0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 16'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (do_write) mem[acc_idx] <= acc_data;
  end
  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign Busy     = !idle;
  assign MemFault = ready_q & fault_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving a WAIT_STATES=2 and a WAIT_STATES=0 responder against a behavioural memory model.
module tb_mem_responder;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst_n = 2'b00, mrd = 2'b00, mwr = 2'b00, rdy, bsy, flt;
  logic [1:0][15:0] adr = '0, wd = '0, rd;
  mem_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(2)) dut_ws2 (
    .CLK(clk), .Reset(rst_n[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .Addr(adr[0]),
    .WriteData(wd[0]), .ReadData(rd[0]), .MemReady(rdy[0]), .Busy(bsy[0]), .MemFault(flt[0]));
  mem_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .CLK(clk), .Reset(rst_n[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .Addr(adr[1]),
    .WriteData(wd[1]), .ReadData(rd[1]), .MemReady(rdy[1]), .Busy(bsy[1]), .MemFault(flt[1]));
  typedef struct {
    logic [15:0] data;
    bit          known;
    bit          fault;
    int          cyc;
  } exp_t;
  exp_t q0[$], q1[$];
  logic [15:0] ram_m [int];
  logic [15:0] rdv [2], shown [2];
  bit rdv_known [2], shown_known [2], prev_rdy [2];
  logic [15:0] pool[$];
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int ws(input int d);
    return d == 0 ? 2 : 0;
  endfunction
  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask
  // Expected response is fixed at issue time from the memory model's rules
  task automatic issue(input int d, input bit r, input bit w, input logic [15:0] a, input logic [15:0] data, input bit abort);
    exp_t e;
    int key;
    bit f;
    @(negedge clk);
    for (int t = 0; t < 40 && bsy[d]; t++) @(negedge clk);
    if (bsy[d]) begin
      check("idle_timeout", d, 32'(bsy[d]), 0);
      return;
    end
    mrd[d] = r; mwr[d] = w; adr[d] = a; wd[d] = data;
    f = r && w;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    f = f || int'(a) >= DEPTH;
`endif
    key = d * DEPTH + int'(a) % DEPTH;
    if (!abort) begin
      if (!f && w) ram_m[key] = data;
      if (!f && r && !w) begin
        rdv_known[d] = ram_m.exists(key);
        rdv[d] = rdv_known[d] ? ram_m[key] : 16'd0;
      end
      e.data = rdv[d]; e.known = rdv_known[d]; e.fault = f; e.cyc = cyc + 1 + ws(d);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    mrd[d] = 1'b0; mwr[d] = 1'b0; adr[d] = 16'($urandom); wd[d] = 16'($urandom);
    check("accepted_busy", d, 32'(bsy[d]), 1);
  endtask
  task automatic reset_dut(input logic [1:0] m, input int n);
    @(negedge clk);
    for (int d = 0; d < 2; d++) if (m[d]) begin
      rst_n[d] = 1'b0; mrd[d] = 1'($urandom); mwr[d] = 1'($urandom);
    end
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (m[d]) begin mrd[d] = 1'($urandom); mwr[d] = 1'($urandom); end
    end
    for (int d = 0; d < 2; d++) if (m[d]) begin
      check("rst_rdata", d, 32'(rd[d]), 0);
      check("rst_ready", d, 32'(rdy[d]), 0);
      check("rst_busy", d, 32'(bsy[d]), 0);
      check("rst_fault", d, 32'(flt[d]), 0);
      if (d == 0) q0.delete(); else q1.delete();
      rdv[d] = 16'd0; rdv_known[d] = 1'b1; shown[d] = 16'd0; shown_known[d] = 1'b1;
      mrd[d] = 1'b0; mwr[d] = 1'b0; rst_n[d] = 1'b1;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] && rdy[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) check("unexpected_ready", d, 32'(rdy[d]), 0);
        else begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          check("ready_cycle", d, cyc, e.cyc);
          check("fault", d, 32'(flt[d]), 32'(e.fault));
          check("busy_in_done", d, 32'(bsy[d]), 1);
          if (e.known) check("read_data", d, 32'(rd[d]), 32'(e.data));
          shown[d] = e.data; shown_known[d] = e.known;
        end
        check("ready_pulse", d, 32'(prev_rdy[d]), 0);
      end else if (rst_n[d]) begin
        check("fault_unqualified", d, 32'(flt[d]), 0);
        if (shown_known[d]) check("read_hold", d, 32'(rd[d]), 32'(shown[d]));
      end
      prev_rdy[d] = rst_n[d] && rdy[d];
    end
  end
  initial begin
    #400000;
    $display("FAIL global_timeout: run did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    int d, k;
    logic [15:0] a;
    bit r, w;
    reset_dut(2'b11, 2);
    pool = '{16'h0000, 16'h0003, 16'h0010, 16'h0020, 16'h0030};
    repeat (6) pool.push_back(16'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 2; i++)
      foreach (pool[j]) issue(i, 0, 1, pool[j], pool[j] == 16'h0003 ? 16'h1234 : 16'($urandom), 0);
    issue(0, 0, 1, 16'h0010, 16'hBEEF, 0);
    issue(0, 1, 0, 16'h0010, 16'h0000, 0);
    issue(1, 1, 0, 16'h0003, 16'h0000, 0);
    issue(1, 1, 0, 16'h0003, 16'h0000, 0);
    issue(0, 1, 1, 16'h0010, 16'h0000, 0);
    issue(0, 1, 0, 16'h0010, 16'h0000, 0);
    issue(0, 1, 0, 16'h0010, 16'h0000, 0);
    mwr[0] = 1'b1; adr[0] = 16'h0020; wd[0] = 16'hDEAD;
    repeat (2) @(negedge clk);
    mwr[0] = 1'b0;
    issue(0, 1, 0, 16'h0020, 16'h0000, 0);
    issue(0, 0, 1, 16'h0030, 16'h5A5A, 1);
    reset_dut(2'b01, 1);
    issue(0, 1, 0, 16'h0030, 16'h0000, 0);
    for (int i = 0; i < 2; i++) begin
      issue(i, 1, 0, 16'h0400, 16'h0000, 0);
      issue(i, 0, 1, 16'hFFFF, 16'h7777, 0);
      issue(i, 1, 0, 16'h03FF, 16'h0000, 0);
    end
    for (int i = 0; i < 80; i++) begin
      d = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      a = k < 7 ? pool[$urandom_range(0, pool.size() - 1)] : 16'($urandom);
      k = $urandom_range(0, 9);
      r = k < 5 || k == 9;
      w = k >= 5;
      issue(d, r, w, a, 16'($urandom), 0);
    end
    for (int t = 0; t < 100 && (bsy != 2'b00 || q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
    @(negedge clk);
    check("drain", 0, 32'(q0.size() + q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
